// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit with HI/LO registers: one bit per cycle, fixed WIDTH+1 cycle latency.
// Optional MADD/MSUB accumulation enabled by defining MDU_MADD_EN.
module mdu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2} state_t;

  state_t               state_r, state_nxt_s;
  logic [CW-1:0]        cnt_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]     opnd_r;
  logic                 div_r, neg_q_r, neg_rem_r;
`ifdef MDU_MADD_EN
  logic                 madd_r, msub_r;
`endif

  logic                 accept_s, mthi_s, mtlo_s, calc_s, fix_s;
  logic                 md_op_s, signed_op_s, div_op_s, sa_s, sb_s, neg_q_s;
  logic [WIDTH-1:0]     mag_a_s, mag_b_s;
  logic [WIDTH:0]       mul_sum_s, div_shift_s, div_diff_s;
  logic [2*WIDTH-1:0]   step_s, prod_fix_s;
  logic [WIDTH-1:0]     quo_fix_s, rem_fix_s;

  // Operation decode and operand magnitude/sign extraction
  always_comb begin
    md_op_s     = 1'b0;
    signed_op_s = 1'b0;
    div_op_s    = 1'b0;
    case (op)
      OP_MULT:  begin md_op_s = 1'b1; signed_op_s = 1'b1; end
      OP_MULTU: begin md_op_s = 1'b1; end
      OP_DIV:   begin md_op_s = 1'b1; signed_op_s = 1'b1; div_op_s = 1'b1; end
      OP_DIVU:  begin md_op_s = 1'b1; div_op_s = 1'b1; end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MSUB: begin md_op_s = 1'b1; signed_op_s = 1'b1; end
`endif
      default:  begin md_op_s = 1'b0; end
    endcase
    sa_s    = signed_op_s & in_a[WIDTH-1];
    sb_s    = signed_op_s & in_b[WIDTH-1];
    mag_a_s = sa_s ? -in_a : in_a;
    mag_b_s = sb_s ? -in_b : in_b;
    // A zero divisor leaves the all-ones quotient uncorrected
    neg_q_s = (sa_s ^ sb_s) & ~(div_op_s & (in_b == {WIDTH{1'b0}}));
  end

  // Next-state logic and per-cycle action strobes
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    mthi_s      = 1'b0;
    mtlo_s      = 1'b0;
    calc_s      = 1'b0;
    fix_s       = 1'b0;
    if (flush) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start && md_op_s) begin
            accept_s    = 1'b1;
            state_nxt_s = S_CALC;
          end else if (start && (op == OP_MTHI)) begin
            mthi_s = 1'b1;
          end else if (start && (op == OP_MTLO)) begin
            mtlo_s = 1'b1;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_CALC: begin
          calc_s = 1'b1;
          if (cnt_r == CNT_LAST) begin
            state_nxt_s = S_FIX;
          end else begin
            state_nxt_s = S_CALC;
          end
        end
        S_FIX: begin
          fix_s       = 1'b1;
          state_nxt_s = S_IDLE;
        end
        default: state_nxt_s = S_IDLE;
      endcase
    end
  end

  // One iteration of shift-add multiply or restoring divide, plus final sign correction
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, (acc_r[0] ? opnd_r : {WIDTH{1'b0}})};
    div_shift_s = acc_r[2*WIDTH-1:WIDTH-1];
    div_diff_s  = div_shift_s - {1'b0, opnd_r};
    if (!div_r) begin
      step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end else if (!div_diff_s[WIDTH]) begin
      step_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end else begin
      step_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    end
    prod_fix_s = neg_q_r ? -acc_r : acc_r;
    quo_fix_s  = neg_q_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
    rem_fix_s  = neg_rem_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath, counter and HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r     <= {CW{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      opnd_r    <= {WIDTH{1'b0}};
      div_r     <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
`ifdef MDU_MADD_EN
      madd_r    <= 1'b0;
      msub_r    <= 1'b0;
`endif
      hi        <= {WIDTH{1'b0}};
      lo        <= {WIDTH{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy <= (state_nxt_s == S_CALC) || (state_nxt_s == S_FIX);
      done <= fix_s;
      if (accept_s) begin
        cnt_r     <= {CW{1'b0}};
        acc_r     <= {{WIDTH{1'b0}}, mag_a_s};
        opnd_r    <= mag_b_s;
        div_r     <= div_op_s;
        neg_q_r   <= neg_q_s;
        neg_rem_r <= div_op_s & sa_s;
`ifdef MDU_MADD_EN
        madd_r    <= (op == OP_MADD);
        msub_r    <= (op == OP_MSUB);
`endif
      end
      if (calc_s) begin
        cnt_r <= cnt_r + CW'(1);
        acc_r <= step_s;
      end
      if (mthi_s) hi <= in_a;
      if (mtlo_s) lo <= in_a;
      if (fix_s) begin
        if (div_r) begin
          hi <= rem_fix_s;
          lo <= quo_fix_s;
`ifdef MDU_MADD_EN
        end else if (madd_r) begin
          {hi, lo} <= {hi, lo} + prod_fix_s;
        end else if (msub_r) begin
          {hi, lo} <= {hi, lo} - prod_fix_s;
`endif
        end else begin
          {hi, lo} <= prod_fix_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed self-checking bench for mdu_iterative (WIDTH=32); MADD/MSUB vectors run when MDU_MADD_EN is defined.
module tb_mdu_iterative;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, flush;
  logic [2:0]   op;
  logic [W-1:0] in_a, in_b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  mdu_iterative #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .in_a(in_a), .in_b(in_b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue a multi-cycle op at a negedge and wait (bounded) for its result
  task automatic run_md(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int n;
    start = 1'b1; op = o; in_a = a; in_b = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, 64'(n), 64'(W + 1));
    check({tag, " done"}, {63'd0, done}, 64'd1);
    check({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
  endtask

  // Single-cycle MTHI/MTLO (or any op expected to stay idle)
  task automatic run_mt(input logic [2:0] o, input logic [W-1:0] a, input logic fl);
    start = 1'b1; op = o; in_a = a; flush = fl;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
  endtask

  initial begin
    int dones;
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset hilo", {hi, lo}, 64'd0);

    run_md("MULT -3*5", 3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    @(negedge clk);
    check("done one-cycle", {63'd0, done}, 64'd0);
    run_md("MULTU max*max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_md("DIV -7/2", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("DIVU 100/0", 3'b011, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
    run_md("DIV -7/0", 3'b010, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_md("DIV min/-1", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_md("DIVU 100/7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14);

    // Flush of an in-flight MULT after an ignored DIV request
    run_mt(3'b100, 32'h1234_5678, 1'b0);
    run_mt(3'b101, 32'h1234_5678, 1'b0);
    check("MTHI/MTLO hilo", {hi, lo}, 64'h1234_5678_1234_5678);
    start = 1'b1; op = 3'b000; in_a = 32'd9; in_b = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; op = 3'b010; in_a = 32'd50; in_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    check("busy during ignored start", {63'd0, busy}, 64'd1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", {63'd0, busy}, 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("flush no done", 64'(dones), 64'd0);
    check("flush hilo kept", {hi, lo}, 64'h1234_5678_1234_5678);
    run_md("MULTU 6*7", 3'b001, 32'd6, 32'd7, 32'd0, 32'd42);

    run_mt(3'b101, 32'hCAFE_BABE, 1'b0);
    check("MTLO lo", {32'd0, lo}, {32'd0, 32'hCAFE_BABE});
    check("MTLO busy/done", {62'd0, busy, done}, 64'd0);
    check("MTLO hi kept", {32'd0, hi}, 64'd0);
    run_mt(3'b101, 32'h0BAD_F00D, 1'b1);
    check("MTLO flushed lo", {32'd0, lo}, {32'd0, 32'hCAFE_BABE});
    run_mt(3'b100, 32'h0BAD_F00D, 1'b1);
    check("MTHI flushed hi", {32'd0, hi}, 64'd0);

`ifdef MDU_MADD_EN
    run_mt(3'b100, 32'd0, 1'b0);
    run_mt(3'b101, 32'd10, 1'b0);
    run_md("MADD 3*4", 3'b110, 32'd3, 32'd4, 32'd0, 32'd22);
    run_md("MSUB 7*7", 3'b111, 32'd7, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFE5);
    run_md("MADD -1*1", 3'b110, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFE4);
`else
    run_mt(3'b110, 32'd3, 1'b0);
    check("op110 busy", {63'd0, busy}, 64'd0);
    run_mt(3'b111, 32'd3, 1'b0);
    check("op111 busy", {63'd0, busy}, 64'd0);
    check("op110/111 done", {63'd0, done}, 64'd0);
    check("op110/111 hilo", {hi, lo}, {32'd0, 32'hCAFE_BABE});
`endif

    // Reset mid-operation aborts it
    start = 1'b1; op = 3'b001; in_a = 32'd3; in_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midop reset busy", {63'd0, busy}, 64'd0);
    check("midop reset hilo", {hi, lo}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
